int_controller: RTL and testbench

Interrupt controller sitting between the I/O device drivers and the CPU sequencer. It captures rising edges on up to 16 device request lines into a pending register and gates them with a mask and a global enable. It raises a single `interrupt` to the CPU, hands over a 4-bit vector on acknowledge, and blocks further requests until the CPU signals return. Mask, pending, enable and vector/in-service state are readable and writable over the 16-bit I/O bus.

---
 rtl/io_pkg.sv | 18 +
 rtl/int_prio_enc.sv | 23 ++
 rtl/int_controller.sv | 132 +++++++++++++
 tb/tb_int_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared I/O definitions: register selects, interrupt FSM states and widths.
package io_pkg;

  localparam int IRQ_W = 16;
  localparam int VEC_W = 4;

  localparam logic [1:0] SEL_MASK = 2'd0;
  localparam logic [1:0] SEL_PEND = 2'd1;
  localparam logic [1:0] SEL_STAT = 2'd2;
  localparam logic [1:0] SEL_EN   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } int_state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder: returns the index of the lowest set
// request bit and whether any bit was set at all.
module int_prio_enc
  import io_pkg::*;
(
  input  logic [IRQ_W-1:0] req_i,
  output logic [VEC_W-1:0] idx_o,
  output logic             found_o
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = IRQ_W - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = VEC_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_controller.sv
// Interrupt controller: captures request edges into pending, gates them by
// mask and global enable, and hands one vector at a time to the CPU.
module int_controller
  import io_pkg::*;
#(
  parameter int N_SRC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IRQ_W-1:0] irq,
  input  logic             read,
  input  logic             write,
  input  logic [1:0]       sel,
  input  logic [IRQ_W-1:0] in_bus,
  output logic [IRQ_W-1:0] out_bus,
  output logic             interrupt,
  input  logic             int_ack,
  input  logic             int_ret,
  output logic [VEC_W-1:0] vector,
  output logic             in_service
);

  // Bits for request lines that are not populated stay permanently zero.
  localparam logic [IRQ_W-1:0] SRC_MASK = IRQ_W'((32'd1 << N_SRC) - 32'd1);

  int_state_e       state_q, state_d;
  logic [IRQ_W-1:0] irq_q;
  logic [IRQ_W-1:0] pending_q, pending_d;
  logic [IRQ_W-1:0] mask_q, mask_d;
  logic             enable_q, enable_d;
  logic [VEC_W-1:0] vector_q, vector_d;

  logic [IRQ_W-1:0] rise;
  logic [IRQ_W-1:0] elig;
  logic [IRQ_W-1:0] sw_clr;
  logic [IRQ_W-1:0] ack_clr;
  logic [VEC_W-1:0] win_idx;
  logic             win_found;
  logic             take_ack;

  assign rise = irq & ~irq_q & SRC_MASK;
  assign elig = enable_q ? (pending_q & mask_q) : '0;

  int_prio_enc u_prio (
    .req_i   (elig),
    .idx_o   (win_idx),
    .found_o (win_found)
  );

  // FSM next state; an acknowledge only counts while something is still eligible.
  always_comb begin
    state_d  = state_q;
    take_ack = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (!win_found) begin
          state_d = ST_IDLE;
        end else if (int_ack) begin
          state_d  = ST_SERVICE;
          take_ack = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (int_ret) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register file next state; a fresh edge always wins over either clear.
  always_comb begin
    mask_d   = mask_q;
    enable_d = enable_q;
    vector_d = vector_q;
    sw_clr   = '0;
    ack_clr  = '0;
    if (write) begin
      case (sel)
        SEL_MASK: mask_d   = in_bus & SRC_MASK;
        SEL_PEND: sw_clr   = in_bus;
        SEL_EN:   enable_d = in_bus[0];
        default:  ;
      endcase
    end
    if (take_ack) begin
      vector_d         = win_idx;
      ack_clr[win_idx] = 1'b1;
    end
    pending_d = ((pending_q & ~sw_clr & ~ack_clr) | rise) & SRC_MASK;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      irq_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      enable_q  <= 1'b0;
      vector_q  <= '0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq & SRC_MASK;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      enable_q  <= enable_d;
      vector_q  <= vector_d;
    end
  end

  assign interrupt  = (state_q == ST_REQ);
  assign in_service = (state_q == ST_SERVICE);
  assign vector     = vector_q;

  // Combinational read mux, quiet when no read is in progress.
  always_comb begin
    out_bus = '0;
    if (read) begin
      case (sel)
        SEL_MASK: out_bus = mask_q;
        SEL_PEND: out_bus = pending_q;
        SEL_STAT: out_bus = {11'b0, in_service, vector_q};
        SEL_EN:   out_bus = {15'b0, enable_q};
        default:  out_bus = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_int_controller.sv
// Table-driven bench for int_controller with a small expectation queue.
module tb_int_controller;
  import io_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] irq;
  logic        read;
  logic        write;
  logic [1:0]  sel;
  logic [15:0] in_bus;
  logic [15:0] out_bus;
  logic        interrupt;
  logic        int_ack;
  logic        int_ret;
  logic [3:0]  vector;
  logic        in_service;

  int tests;
  int fails;

  typedef struct {
    logic [15:0] irq;
    logic        wr;
    logic [1:0]  sel;
    logic [15:0] din;
    logic        ack;
    logic        ret;
    logic        e_int;
    logic        e_svc;
    logic [3:0]  e_vec;
    logic [15:0] e_pend;
  } vec_t;

  typedef struct {
    int          row;
    logic        e_int;
    logic        e_svc;
    logic [3:0]  e_vec;
    logic [15:0] e_pend;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  int_controller #(.N_SRC(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq        (irq),
    .read       (read),
    .write      (write),
    .sel        (sel),
    .in_bus     (in_bus),
    .out_bus    (out_bus),
    .interrupt  (interrupt),
    .int_ack    (int_ack),
    .int_ret    (int_ret),
    .vector     (vector),
    .in_service (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int row, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic rd(input logic [1:0] s, output logic [15:0] v);
    read = 1'b1;
    sel  = s;
    #1;
    v    = out_bus;
    read = 1'b0;
  endtask

  // irq, wr, sel, din, ack, ret | interrupt, in_service, vector, pending
  task automatic row(input logic [15:0] i, input logic w, input logic [1:0] s, input logic [15:0] d,
                     input logic a, input logic r, input logic ei, input logic es,
                     input logic [3:0] ev, input logic [15:0] ep);
    tbl.push_back(vec_t'{i, w, s, d, a, r, ei, es, ev, ep});
  endtask

  initial begin
    logic [15:0] v;
    exp_t e;
    tests = 0;
    fails = 0;
    rst = 1'b1; irq = '0; read = 1'b0; write = 1'b0; sel = '0;
    in_bus = '0; int_ack = 1'b0; int_ret = 1'b0;

    // basic request / acknowledge / return on source 2
    row(16'h0000, 1, SEL_EN,   16'h0001, 0, 0, 0, 0, 4'd0, 16'h0000);
    row(16'h0000, 1, SEL_MASK, 16'h0004, 0, 0, 0, 0, 4'd0, 16'h0000);
    row(16'h0004, 0, SEL_MASK, 16'h0000, 0, 0, 0, 0, 4'd0, 16'h0004);
    row(16'h0000, 0, SEL_MASK, 16'h0000, 0, 0, 1, 0, 4'd0, 16'h0004);
    row(16'h0000, 0, SEL_MASK, 16'h0000, 0, 0, 1, 0, 4'd0, 16'h0004);
    row(16'h0000, 0, SEL_MASK, 16'h0000, 1, 0, 0, 1, 4'd2, 16'h0000);
    row(16'h0000, 0, SEL_MASK, 16'h0000, 0, 0, 0, 1, 4'd2, 16'h0000);
    row(16'h0000, 0, SEL_MASK, 16'h0000, 0, 1, 0, 0, 4'd2, 16'h0000);
    row(16'h0000, 0, SEL_MASK, 16'h0000, 0, 0, 0, 0, 4'd2, 16'h0000);
    // two pending sources, priority and 1-cycle gap between handlers
    row(16'h0000, 1, SEL_MASK, 16'hFFFF, 0, 0, 0, 0, 4'd2, 16'h0000);
    row(16'h0014, 0, SEL_MASK, 16'h0000, 0, 0, 0, 0, 4'd2, 16'h0014);
    row(16'h0014, 0, SEL_MASK, 16'h0000, 0, 0, 1, 0, 4'd2, 16'h0014);
    row(16'h0014, 0, SEL_MASK, 16'h0000, 1, 0, 0, 1, 4'd2, 16'h0010);
    row(16'h0014, 0, SEL_MASK, 16'h0000, 0, 1, 0, 0, 4'd2, 16'h0010);
    row(16'h0014, 0, SEL_MASK, 16'h0000, 0, 0, 1, 0, 4'd2, 16'h0010);
    row(16'h0014, 0, SEL_MASK, 16'h0000, 1, 0, 0, 1, 4'd4, 16'h0000);
    row(16'h0000, 0, SEL_MASK, 16'h0000, 0, 1, 0, 0, 4'd4, 16'h0000);
    // masked source accumulates, unmasking raises the request
    row(16'h0000, 1, SEL_MASK, 16'h0000, 0, 0, 0, 0, 4'd4, 16'h0000);
    row(16'h0020, 0, SEL_MASK, 16'h0000, 0, 0, 0, 0, 4'd4, 16'h0020);
    row(16'h0000, 0, SEL_MASK, 16'h0000, 0, 0, 0, 0, 4'd4, 16'h0020);
    row(16'h0000, 0, SEL_MASK, 16'h0000, 0, 0, 0, 0, 4'd4, 16'h0020);
    row(16'h0000, 1, SEL_MASK, 16'h0020, 0, 0, 0, 0, 4'd4, 16'h0020);
    row(16'h0000, 0, SEL_MASK, 16'h0000, 0, 0, 1, 0, 4'd4, 16'h0020);
    // W1C of the only pending source while in REQ, late ack ignored
    row(16'h0000, 1, SEL_PEND, 16'h0020, 0, 0, 1, 0, 4'd4, 16'h0000);
    row(16'h0000, 0, SEL_MASK, 16'h0000, 1, 0, 0, 0, 4'd4, 16'h0000);
    row(16'h0000, 0, SEL_MASK, 16'h0000, 1, 0, 0, 0, 4'd4, 16'h0000);
    // new edge on source 3 in the same cycle as its acknowledge
    row(16'h0000, 1, SEL_MASK, 16'hFFFF, 0, 0, 0, 0, 4'd4, 16'h0000);
    row(16'h0008, 0, SEL_MASK, 16'h0000, 0, 0, 0, 0, 4'd4, 16'h0008);
    row(16'h0000, 0, SEL_MASK, 16'h0000, 0, 0, 1, 0, 4'd4, 16'h0008);
    row(16'h0008, 0, SEL_MASK, 16'h0000, 1, 0, 0, 1, 4'd3, 16'h0008);
    row(16'h0008, 0, SEL_MASK, 16'h0000, 0, 0, 0, 1, 4'd3, 16'h0008);
    row(16'h0000, 0, SEL_MASK, 16'h0000, 0, 1, 0, 0, 4'd3, 16'h0008);
    row(16'h0000, 0, SEL_MASK, 16'h0000, 0, 0, 1, 0, 4'd3, 16'h0008);
    row(16'h0000, 0, SEL_MASK, 16'h0000, 1, 0, 0, 1, 4'd3, 16'h0000);
    row(16'h0000, 0, SEL_MASK, 16'h0000, 0, 1, 0, 0, 4'd3, 16'h0000);
    // ack clear together with software clear, then edge against software clear
    row(16'h0002, 0, SEL_MASK, 16'h0000, 0, 0, 0, 0, 4'd3, 16'h0002);
    row(16'h0000, 0, SEL_MASK, 16'h0000, 0, 0, 1, 0, 4'd3, 16'h0002);
    row(16'h0000, 1, SEL_PEND, 16'h0002, 1, 0, 0, 1, 4'd1, 16'h0000);
    row(16'h0000, 0, SEL_MASK, 16'h0000, 0, 1, 0, 0, 4'd1, 16'h0000);
    row(16'h0001, 1, SEL_PEND, 16'h0001, 0, 0, 0, 0, 4'd1, 16'h0001);
    row(16'h0000, 0, SEL_MASK, 16'h0000, 0, 0, 1, 0, 4'd1, 16'h0001);
    // global enable gating
    row(16'h0000, 1, SEL_EN,   16'h0000, 0, 0, 1, 0, 4'd1, 16'h0001);
    row(16'h0000, 0, SEL_MASK, 16'h0000, 0, 0, 0, 0, 4'd1, 16'h0001);
    row(16'h0000, 1, SEL_EN,   16'h0001, 0, 0, 0, 0, 4'd1, 16'h0001);
    row(16'h0000, 0, SEL_MASK, 16'h0000, 0, 0, 1, 0, 4'd1, 16'h0001);
    row(16'h0000, 0, SEL_MASK, 16'h0000, 1, 0, 0, 1, 4'd0, 16'h0000);
    row(16'h0010, 0, SEL_MASK, 16'h0000, 0, 0, 0, 1, 4'd0, 16'h0010);

    // reset state while rst is held
    #12;
    chk("rst_interrupt", -1, {15'b0, interrupt}, 16'h0000);
    chk("rst_in_service", -1, {15'b0, in_service}, 16'h0000);
    chk("rst_vector", -1, {12'b0, vector}, 16'h0000);
    chk("rst_out_idle", -1, out_bus, 16'h0000);
    rd(SEL_MASK, v); chk("rst_mask", -1, v, 16'h0000);
    rd(SEL_PEND, v); chk("rst_pend", -1, v, 16'h0000);
    rd(SEL_EN, v);   chk("rst_enable", -1, v, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      irq     = tbl[i].irq;
      write   = tbl[i].wr;
      sel     = tbl[i].sel;
      in_bus  = tbl[i].din;
      int_ack = tbl[i].ack;
      int_ret = tbl[i].ret;
      sb.push_back(exp_t'{i, tbl[i].e_int, tbl[i].e_svc, tbl[i].e_vec, tbl[i].e_pend});
      @(posedge clk);
      #1;
      write = 1'b0; int_ack = 1'b0; int_ret = 1'b0;
      e = sb.pop_front();
      chk("interrupt", e.row, {15'b0, interrupt}, {15'b0, e.e_int});
      chk("in_service", e.row, {15'b0, in_service}, {15'b0, e.e_svc});
      chk("vector", e.row, {12'b0, vector}, {12'b0, e.e_vec});
      rd(SEL_PEND, v); chk("pending", e.row, v, e.e_pend);
      rd(SEL_STAT, v); chk("status", e.row, v, {11'b0, e.e_svc, e.e_vec});
      #1;
      chk("out_idle", e.row, out_bus, 16'h0000);
      $display("[TB] row %0d irq=%h int=%b svc=%b vec=%0d pend=%h", e.row, irq, interrupt, in_service, vector, e.e_pend);
    end

    // asynchronous reset in the middle of a handler, away from any clock edge
    @(negedge clk);
    #2;
    rd(SEL_MASK, v); chk("pre_rst_mask", 100, v, 16'hFFFF);
    rst = 1'b1;
    #1;
    chk("arst_in_service", 100, {15'b0, in_service}, 16'h0000);
    chk("arst_interrupt", 100, {15'b0, interrupt}, 16'h0000);
    rd(SEL_MASK, v); chk("arst_mask", 100, v, 16'h0000);
    rd(SEL_PEND, v); chk("arst_pend", 100, v, 16'h0000);
    rd(SEL_EN, v);   chk("arst_enable", 100, v, 16'h0000);
    rd(SEL_STAT, v); chk("arst_status", 100, v, 16'h0000);
    $display("[TB] async reset during service checked");
    @(negedge clk);
    irq = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
